// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N packet demultiplexer for a valid/ready stream.
// The destination is captured on the first beat of a packet and held until
// the last beat is accepted; out-of-range destinations drop the whole packet.
module stream_demux_1ton #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_OUT  = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic [SEL_W-1:0]  s_sel,
  output logic [N_OUT-1:0]  m_valid,
  input  logic [N_OUT-1:0]  m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              sel_err,
  output logic              busy
);

  localparam int unsigned N_SEL = 2 ** SEL_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUTE = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [SEL_W-1:0]  r_dest;
  logic [N_OUT-1:0]  r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic              r_m_last;
  logic              r_sel_err;

  logic [N_SEL-1:0]  w_sel_mask;
  logic              w_sel_ok;
  logic              w_out_full;
  logic              w_drain;
  logic              w_s_ready;
  logic              w_acc;
  logic              w_fwd;
  logic              w_drop_first;
  logic              w_load_dest;
  logic [SEL_W-1:0]  w_fwd_dest;
  logic [N_OUT-1:0]  w_onehot;

  // Table of which select codes name an existing channel
  for (genvar g = 0; g < N_SEL; g++) begin : g_sel_mask
    assign w_sel_mask[g] = (g < N_OUT) ? 1'b1 : 1'b0;
  end

  assign w_sel_ok   = w_sel_mask[s_sel];
  assign w_out_full = |r_m_valid;
  // Drain uses the channel of the beat currently held, not the locked dest
  assign w_drain    = |(r_m_valid & m_ready);

  // Next-state, handshake and routing decisions
  always_comb begin
    w_state_nxt  = r_state;
    w_s_ready    = ~w_out_full | w_drain;
    w_fwd_dest   = r_dest;
    w_acc        = 1'b0;
    w_fwd        = 1'b0;
    w_drop_first = 1'b0;
    w_load_dest  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_fwd_dest = s_sel;
        // A discarded first beat never needs the output register
        if (!w_sel_ok) w_s_ready = 1'b1;
        w_acc = s_valid & w_s_ready;
        if (w_acc) begin
          w_fwd        = w_sel_ok;
          w_load_dest  = w_sel_ok;
          w_drop_first = ~w_sel_ok;
          if (!s_last) w_state_nxt = w_sel_ok ? ST_ROUTE : ST_DROP;
        end
      end
      ST_ROUTE: begin
        w_acc = s_valid & w_s_ready;
        w_fwd = w_acc;
        if (w_acc && s_last) w_state_nxt = ST_IDLE;
      end
      ST_DROP: begin
        w_s_ready = 1'b1;
        w_acc     = s_valid;
        if (w_acc && s_last) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_onehot = N_OUT'(1) << w_fwd_dest;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Output stage, locked destination and select-error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= '0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
      r_sel_err <= 1'b0;
      r_dest    <= '0;
    end else begin
      r_sel_err <= w_drop_first;
      if (w_load_dest) r_dest <= s_sel;
      if (w_fwd) begin
        r_m_valid <= w_onehot;
        r_m_data  <= s_data;
        r_m_last  <= s_last;
      end else if (w_drain) begin
        r_m_valid <= '0;
      end
    end
  end

  assign s_ready = w_s_ready;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_last  = r_m_last;
  assign sel_err = r_sel_err;
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Scoreboard bench for stream_demux_1ton: a 4-channel and a 3-channel instance.
module tb_stream_demux_1ton;

  logic       clk;
  logic       rst_n;
  logic [1:0] s_sel;
  logic [7:0] s_data;
  logic       s_last;

  logic       s_valid_a, s_ready_a, m_last_a, sel_err_a, busy_a;
  logic [3:0] m_valid_a, m_ready_a;
  logic [7:0] m_data_a;

  logic       s_valid_b, s_ready_b, m_last_b, sel_err_b, busy_b;
  logic [2:0] m_valid_b, m_ready_b;
  logic [7:0] m_data_b;

  typedef struct packed {
    logic [31:0] ch;
    logic [7:0]  d;
    logic        l;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   cyc_log[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  stream_demux_1ton #(.DATA_W(8), .N_OUT(4), .SEL_W(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid_a), .s_ready(s_ready_a),
    .s_data(s_data), .s_last(s_last), .s_sel(s_sel), .m_valid(m_valid_a),
    .m_ready(m_ready_a), .m_data(m_data_a), .m_last(m_last_a),
    .sel_err(sel_err_a), .busy(busy_a)
  );

  stream_demux_1ton #(.DATA_W(8), .N_OUT(3), .SEL_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid_b), .s_ready(s_ready_b),
    .s_data(s_data), .s_last(s_last), .s_sel(s_sel), .m_valid(m_valid_b),
    .m_ready(m_ready_b), .m_data(m_data_b), .m_last(m_last_b),
    .sel_err(sel_err_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] idx(input logic [3:0] v);
    logic [31:0] r;
    r = 32'hFFFF_FFFF;
    for (int i = 3; i >= 0; i--) if (v[i]) r = 32'(i);
    return r;
  endfunction

  // Monitor A: one-hot, hold stability, and scoreboard pop on every drain
  logic [3:0] pv_a;
  logic [7:0] pd_a;
  logic       pl_a;
  logic       ph_a = 1'b0;
  exp_t       e_a;
  always @(negedge clk) begin
    if (!rst_n) begin
      ph_a <= 1'b0;
    end else begin
      chk("onehot_a", 32'($onehot0(m_valid_a)), 32'd1);
      if (ph_a) begin
        chk("hold_valid_a", 32'(m_valid_a), 32'(pv_a));
        chk("hold_data_a", 32'(m_data_a), 32'(pd_a));
        chk("hold_last_a", 32'(m_last_a), 32'(pl_a));
      end
      if (|(m_valid_a & m_ready_a)) begin
        if (q_a.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat_a: got data 0x%0h on valid %b, expected none", m_data_a, m_valid_a);
        end else begin
          e_a = q_a.pop_front();
          chk("chan_a", idx(m_valid_a), e_a.ch);
          chk("data_a", 32'(m_data_a), 32'(e_a.d));
          chk("last_a", 32'(m_last_a), 32'(e_a.l));
          cyc_log.push_back(cyc);
        end
      end
      ph_a <= |(m_valid_a & ~m_ready_a);
      pv_a <= m_valid_a;
      pd_a <= m_data_a;
      pl_a <= m_last_a;
    end
  end

  // Monitor B: one-hot and scoreboard pop on every drain
  exp_t e_b;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("onehot_b", 32'($onehot0(m_valid_b)), 32'd1);
      if (|(m_valid_b & m_ready_b)) begin
        if (q_b.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat_b: got data 0x%0h on valid %b, expected none", m_data_b, m_valid_b);
        end else begin
          e_b = q_b.pop_front();
          chk("chan_b", idx({1'b0, m_valid_b}), e_b.ch);
          chk("data_b", 32'(m_data_b), 32'(e_b.d));
          chk("last_b", 32'(m_last_b), 32'(e_b.l));
        end
      end
    end
  end

  // Present one beat until accepted; ch < 0 means the beat must be discarded
  task automatic send(input int inst, input logic [1:0] sel, input logic [7:0] d,
                      input logic last, input int ch, output int waited);
    exp_t e;
    bit   done;
    logic rdy;
    done   = 1'b0;
    waited = 0;
    s_sel  = sel;
    s_data = d;
    s_last = last;
    if (inst == 0) s_valid_a = 1'b1;
    else           s_valid_b = 1'b1;
    while (!done) begin
      @(negedge clk);
      rdy = (inst == 0) ? s_ready_a : s_ready_b;
      if (rdy) begin
        if (ch >= 0) begin
          e.ch = 32'(ch);
          e.d  = d;
          e.l  = last;
          if (inst == 0) q_a.push_back(e);
          else           q_b.push_back(e);
        end
        done = 1'b1;
      end else if (waited >= 50) begin
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout: beat 0x%0h not accepted after %0d cycles, expected acceptance", d, waited);
        done = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    s_valid_a = 1'b0;
    s_valid_b = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 30) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 32'(q_a.size() + q_b.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_consecutive(input string name, input int n);
    chk({name, "_count"}, 32'(cyc_log.size()), 32'(n));
    for (int i = 1; i < cyc_log.size(); i++)
      chk(name, 32'(cyc_log[i] - cyc_log[i-1]), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b0;
    s_sel = 2'd0; s_data = 8'h00; s_last = 1'b0;
    s_valid_a = 1'b0; s_valid_b = 1'b0;
    m_ready_a = 4'hF; m_ready_b = 3'h7;
    #1;
    // Reset state
    chk("rst_m_valid_a", 32'(m_valid_a), 32'd0);
    chk("rst_m_data_a", 32'(m_data_a), 32'd0);
    chk("rst_m_last_a", 32'(m_last_a), 32'd0);
    chk("rst_sel_err_a", 32'(sel_err_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_s_ready_a", 32'(s_ready_a), 32'd1);
    chk("rst_m_valid_b", 32'(m_valid_b), 32'd0);
    chk("rst_s_ready_b", 32'(s_ready_b), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-beat routing
    send(0, 2'd2, 8'hA5, 1'b1, 2, w);
    chk("t1_m_valid", 32'(m_valid_a), 32'h4);
    chk("t1_m_data", 32'(m_data_a), 32'hA5);
    chk("t1_m_last", 32'(m_last_a), 32'd1);
    @(posedge clk);
    #1;
    chk("t1_m_valid_after", 32'(m_valid_a), 32'd0);
    drain();

    // Packet lock: later s_sel values ignored
    cyc_log.delete();
    send(0, 2'd1, 8'h21, 1'b0, 1, w);
    chk("t2_busy_mid", 32'(busy_a), 32'd1);
    send(0, 2'd3, 8'h22, 1'b0, 1, w);
    send(0, 2'd3, 8'h23, 1'b1, 1, w);
    chk("t2_busy_end", 32'(busy_a), 32'd0);
    drain();
    chk_consecutive("t2_gap", 3);

    // Backpressure on channel 0
    cyc_log.delete();
    m_ready_a = 4'b1110;
    fork
      begin
        send(0, 2'd0, 8'h10, 1'b0, 0, w);
        send(0, 2'd0, 8'h11, 1'b0, 0, w);
        send(0, 2'd0, 8'h12, 1'b0, 0, w);
        send(0, 2'd0, 8'h13, 1'b1, 0, w);
      end
      begin
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t3_s_ready_stall", 32'(s_ready_a), 32'd0);
        chk("t3_m_valid_stall", 32'(m_valid_a), 32'h1);
        chk("t3_m_data_stall", 32'(m_data_a), 32'h10);
        @(posedge clk);
        @(posedge clk);
        #1;
        m_ready_a = 4'hF;
      end
    join
    drain();
    chk_consecutive("t3_gap", 4);

    // Invalid select on the 3-channel instance, with a beat held in its output
    m_ready_b = 3'b000;
    send(1, 2'd1, 8'h3F, 1'b1, 1, w);
    send(1, 2'd3, 8'h40, 1'b0, -1, w);
    chk("t4_wait0", 32'(w), 32'd0);
    chk("t4_sel_err_hi", 32'(sel_err_b), 32'd1);
    chk("t4_busy", 32'(busy_b), 32'd1);
    send(1, 2'd3, 8'h41, 1'b0, -1, w);
    chk("t4_wait1", 32'(w), 32'd0);
    chk("t4_sel_err_lo", 32'(sel_err_b), 32'd0);
    send(1, 2'd0, 8'h42, 1'b0, -1, w);
    chk("t4_wait2", 32'(w), 32'd0);
    send(1, 2'd2, 8'h43, 1'b1, -1, w);
    chk("t4_wait3", 32'(w), 32'd0);
    chk("t4_busy_end", 32'(busy_b), 32'd0);
    chk("t4_held", 32'(m_valid_b), 32'h2);
    m_ready_b = 3'b111;
    send(1, 2'd0, 8'h50, 1'b0, 0, w);
    send(1, 2'd0, 8'h51, 1'b1, 0, w);
    drain();

    // Back-to-back packets to different channels
    cyc_log.delete();
    send(0, 2'd0, 8'h01, 1'b0, 0, w);
    send(0, 2'd0, 8'h02, 1'b1, 0, w);
    send(0, 2'd3, 8'h03, 1'b1, 3, w);
    drain();
    chk_consecutive("t5_gap", 3);

    // Asynchronous reset in the middle of a packet
    send(0, 2'd2, 8'h60, 1'b0, 2, w);
    send(0, 2'd2, 8'h61, 1'b0, 2, w);
    s_sel = 2'd2; s_data = 8'h62; s_last = 1'b0; s_valid_a = 1'b1;
    #1;
    chk("t6_pre_valid", 32'(m_valid_a), 32'h4);
    chk("t6_pre_busy", 32'(busy_a), 32'd1);
    #1;
    rst_n = 1'b0;
    q_a.delete();
    #1;
    chk("t6_rst_valid", 32'(m_valid_a), 32'd0);
    chk("t6_rst_busy", 32'(busy_a), 32'd0);
    chk("t6_rst_data", 32'(m_data_a), 32'd0);
    s_valid_a = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t6_ready_after", 32'(s_ready_a), 32'd1);
    send(0, 2'd1, 8'h70, 1'b1, 1, w);
    chk("t6_route_valid", 32'(m_valid_a), 32'h2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
